// File: rtl/ahb_arbiter.sv
// ahb_arbiter -- round-robin AHB bus arbiter with fixed-length burst hold.
// The grant parks on master 0 when the bus is idle. A fixed-length burst
// (WRAP4..INCR16) keeps the grant until its last SEQ beat is accepted or an
// ERROR response arrives.
// Optional feature: define AHB_ARB_LOCK_EN to add locked-transfer support
// (ARB_LOCKED state and registered Hmastlock). Without it Hlock is ignored
// and Hmastlock is tied low.

`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

module ahb_arbiter #(
  parameter int NUM_MASTERS  = `NUM_MASTERS,
  parameter int MASTER_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  input  logic [NUM_MASTERS-1:0]    Hbusreq,
  input  logic [NUM_MASTERS-1:0]    Hlock,
  input  logic [2*NUM_MASTERS-1:0]  Htrans,
  input  logic [3*NUM_MASTERS-1:0]  Hburst,
  input  logic                      Hready,
  input  logic [1:0]                Hresp,
  output logic [NUM_MASTERS-1:0]    Hgrant,
  output logic [MASTER_WIDTH-1:0]   Hmaster,
  output logic                      Hmastlock
);

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_OWNED  = 2'd1;
  localparam logic [1:0] ARB_BURST  = 2'd2;
  localparam logic [1:0] ARB_LOCKED = 2'd3;

  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  logic [1:0]              state, state_nxt;
  logic [MASTER_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [3:0]              beat_cnt, beat_cnt_nxt;
  logic [NUM_MASTERS-1:0]  grant_nxt;

  logic [MASTER_WIDTH-1:0] grant_idx;
  logic [1:0]              owner_trans;
  logic [2:0]              owner_burst;
  logic                    owner_granted;
  logic                    burst_start;
  logic [3:0]              burst_len;
  logic                    rr_found;
  logic [MASTER_WIDTH-1:0] rr_idx;
  logic                    rearb;

`ifdef AHB_ARB_LOCK_EN
  logic lock_start;
  logic lock_tail, lock_tail_nxt;
`else
  logic unused_lock;
  assign unused_lock = ^Hlock;
`endif

  // Encode the one-hot grant into the index of the granted master.
  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (Hgrant[i]) grant_idx = MASTER_WIDTH'(i);
  end

  // Select the transfer type and burst type driven by the address-phase owner.
  always_comb begin
    owner_trans = '0;
    owner_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (Hmaster == MASTER_WIDTH'(i)) begin
        owner_trans = Htrans[2*i +: 2];
        owner_burst = Hburst[3*i +: 3];
      end
  end

  assign owner_granted = |(Hgrant & (NUM_MASTERS'(1) << Hmaster));
  // A burst is held only if its owner still holds the grant, so that the
  // held grant and the next Hmaster stay the same master.
  assign burst_start   = owner_granted && (owner_trans == TRANS_NONSEQ) &&
                         (owner_burst >= 3'd2);

  // Beats remaining after the NONSEQ beat: 4, 8 or 16-beat bursts.
  always_comb begin
    case (owner_burst)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
  end

`ifdef AHB_ARB_LOCK_EN
  assign lock_start = Hlock[grant_idx] & Hbusreq[grant_idx];
`endif

  // Round-robin search starting one past the last granted master.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++)
      if (!rr_found && Hbusreq[(int'(rr_ptr) + k) % NUM_MASTERS]) begin
        rr_found = 1'b1;
        rr_idx   = MASTER_WIDTH'((int'(rr_ptr) + k) % NUM_MASTERS);
      end
  end

  // Next-state logic: decide whether to hold the current grant or re-arbitrate.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = Hgrant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    rearb        = 1'b0;
`ifdef AHB_ARB_LOCK_EN
    lock_tail_nxt = lock_tail;
`endif
    case (state)
      ARB_BURST: begin
        if (Hresp == RESP_ERROR) begin
          beat_cnt_nxt = 4'd0;
          rearb        = 1'b1;
        end else if (owner_trans == TRANS_SEQ) begin
          if (beat_cnt <= 4'd1) begin
            beat_cnt_nxt = 4'd0;
            rearb        = 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt - 4'd1;
          end
        end
      end
`ifdef AHB_ARB_LOCK_EN
      ARB_LOCKED: begin
        // Hold until Hlock drops, then for one more accepted transfer.
        if (Hlock[grant_idx]) begin
          lock_tail_nxt = 1'b0;
        end else if (lock_tail) begin
          lock_tail_nxt = 1'b0;
          rearb         = 1'b1;
        end else begin
          lock_tail_nxt = 1'b1;
        end
      end
`endif
      default: begin
        if (burst_start) begin
          state_nxt    = ARB_BURST;
          beat_cnt_nxt = burst_len;
`ifdef AHB_ARB_LOCK_EN
        end else if (lock_start) begin
          state_nxt     = ARB_LOCKED;
          lock_tail_nxt = 1'b0;
`endif
        end else begin
          rearb = 1'b1;
        end
      end
    endcase

    if (rearb) begin
      if (rr_found) begin
        grant_nxt  = NUM_MASTERS'(1) << rr_idx;
        rr_ptr_nxt = rr_idx;
        state_nxt  = ARB_OWNED;
      end else begin
        grant_nxt  = NUM_MASTERS'(1);
        state_nxt  = ARB_IDLE;
      end
    end
  end

  // Arbiter state registers; Hready low freezes everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= ARB_IDLE;
      Hgrant   <= NUM_MASTERS'(1);
      Hmaster  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (Hready) begin
      state    <= state_nxt;
      Hgrant   <= grant_nxt;
      Hmaster  <= grant_idx;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  // Lock tail flag and Hmastlock, which follows Hmaster's registered Hlock.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      lock_tail <= 1'b0;
      Hmastlock <= 1'b0;
    end else if (Hready) begin
      lock_tail <= lock_tail_nxt;
      Hmastlock <= Hlock[grant_idx];
    end
  end
`else
  assign Hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (4 masters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  logic           Hclk = 1'b0;
  logic           Hresetn;
  logic [N-1:0]   Hbusreq;
  logic [N-1:0]   Hlock;
  logic [2*N-1:0] Htrans;
  logic [3*N-1:0] Hburst;
  logic           Hready;
  logic [1:0]     Hresp;
  logic [N-1:0]   Hgrant;
  logic [MW-1:0]  Hmaster;
  logic           Hmastlock;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.NUM_MASTERS(N), .MASTER_WIDTH(MW)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Htrans    (Htrans),
    .Hburst    (Hburst),
    .Hready    (Hready),
    .Hresp     (Hresp),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmastlock (Hmastlock)
  );

  always #5 Hclk = ~Hclk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Hclk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    Hbusreq = '0;
    Hlock   = '0;
    Htrans  = '0;
    Hburst  = '0;
    Hready  = 1'b1;
    Hresp   = 2'b00;
  endtask

  task automatic set_master(input int m, input logic [1:0] t, input logic [2:0] b);
    Htrans[2*m +: 2] = t;
    Hburst[3*m +: 3] = b;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    clear_inputs();
    step(2);
    Hresetn = 1'b1;
  endtask

  // Bring M1 to address-phase owner with grant still on M1, state ARB_OWNED.
  task automatic make_m1_owner();
    do_reset();
    Hbusreq = 4'b0010;
    step(2);
  endtask

  task automatic test_reset();
    Hresetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Hbusreq = N'($urandom);
      Hlock   = N'($urandom);
      Htrans  = (2*N)'($urandom);
      Hburst  = (3*N)'($urandom);
      Hready  = 1'($urandom);
      Hresp   = 2'($urandom);
      step(1);
    end
    checks++; if (Hgrant !== 4'b0001) begin errors++; $display("FAIL reset_grant got %b want 0001", Hgrant); end
    checks++; if (Hmaster !== 2'd0) begin errors++; $display("FAIL reset_master got %0d want 0", Hmaster); end
    checks++; if (Hmastlock !== 1'b0) begin errors++; $display("FAIL reset_mastlock got %b want 0", Hmastlock); end
    clear_inputs();
    Hresetn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [MW-1:0] exp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    Hbusreq = 4'b1111;
    for (int m = 0; m < N; m++) set_master(m, 2'd2, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (Hgrant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, Hgrant, exp_g[i]); end
      checks++; if (Hmaster !== exp_m[i]) begin errors++; $display("FAIL rr_master[%0d] got %0d want %0d", i, Hmaster, exp_m[i]); end
    end
  endtask

  task automatic test_latency_park();
    do_reset();
    Hbusreq = 4'b0100;
    step(1);
    checks++; if (Hgrant !== 4'b0100) begin errors++; $display("FAIL lat_grant got %b want 0100", Hgrant); end
    checks++; if (Hmaster !== 2'd0) begin errors++; $display("FAIL lat_master_t1 got %0d want 0", Hmaster); end
    step(1);
    checks++; if (Hmaster !== 2'd2) begin errors++; $display("FAIL lat_master_t2 got %0d want 2", Hmaster); end
    Hbusreq = 4'b0000;
    step(1);
    checks++; if (Hgrant !== 4'b0001) begin errors++; $display("FAIL park_grant got %b want 0001", Hgrant); end
    step(1);
    checks++; if (Hmaster !== 2'd0) begin errors++; $display("FAIL park_master got %0d want 0", Hmaster); end
  endtask

  task automatic test_burst_hold();
    // Beats: NONSEQ, SEQ, BUSY, SEQ, SEQ(last)
    logic [1:0]   tr    [5] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
    logic [N-1:0] exp_g [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    make_m1_owner();
    Hbusreq = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      set_master(1, tr[i], 3'd3);
      step(1);
      checks++; if (Hgrant !== exp_g[i]) begin errors++; $display("FAIL burst_grant[%0d] got %b want %b", i, Hgrant, exp_g[i]); end
    end
    set_master(1, 2'd0, 3'd0);
    checks++; if (Hmaster !== 2'd1) begin errors++; $display("FAIL burst_master_last got %0d want 1", Hmaster); end
    step(1);
    checks++; if (Hmaster !== 2'd2) begin errors++; $display("FAIL burst_master_next got %0d want 2", Hmaster); end
  endtask

  task automatic test_wait_error();
    make_m1_owner();
    Hbusreq = 4'b0110;
    set_master(1, 2'd2, 3'd5);   // NONSEQ INCR8
    step(1);
    set_master(1, 2'd3, 3'd5);   // SEQ beat 2
    step(1);
    Hready  = 1'b0;
    Hbusreq = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (Hgrant !== 4'b0010) begin errors++; $display("FAIL wait_grant[%0d] got %b want 0010", i, Hgrant); end
      checks++; if (Hmaster !== 2'd1) begin errors++; $display("FAIL wait_master[%0d] got %0d want 1", i, Hmaster); end
    end
    Hready  = 1'b1;
    Hbusreq = 4'b0110;
    step(1);
    checks++; if (dut.beat_cnt !== 4'd5) begin errors++; $display("FAIL wait_cnt got %0d want 5", dut.beat_cnt); end
    Hresp  = 2'b01;
    Hready = 1'b0;
    step(1);
    checks++; if (Hgrant !== 4'b0010) begin errors++; $display("FAIL err_wait_grant got %b want 0010", Hgrant); end
    Hready = 1'b1;
    step(1);
    checks++; if (Hgrant !== 4'b0100) begin errors++; $display("FAIL err_grant got %b want 0100", Hgrant); end
    checks++; if (dut.beat_cnt !== 4'd0) begin errors++; $display("FAIL err_cnt got %0d want 0", dut.beat_cnt); end
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    Hbusreq = 4'b1001;
    Hlock   = 4'b1000;
    step(1);
    checks++; if (Hgrant !== 4'b1000) begin errors++; $display("FAIL lock_grant1 got %b want 1000", Hgrant); end
`ifdef AHB_ARB_LOCK_EN
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++; if (Hgrant !== 4'b1000) begin errors++; $display("FAIL lock_hold[%0d] got %b want 1000", i, Hgrant); end
      checks++; if (Hmastlock !== 1'b1) begin errors++; $display("FAIL lock_mastlock[%0d] got %b want 1", i, Hmastlock); end
    end
    Hlock = 4'b0000;
    step(1);
    checks++; if (Hgrant !== 4'b1000) begin errors++; $display("FAIL lock_tail_grant got %b want 1000", Hgrant); end
    checks++; if (Hmastlock !== 1'b0) begin errors++; $display("FAIL lock_tail_mastlock got %b want 0", Hmastlock); end
    step(1);
    checks++; if (Hgrant !== 4'b0001) begin errors++; $display("FAIL lock_release got %b want 0001", Hgrant); end
`else
    step(1);
    checks++; if (Hgrant !== 4'b0001) begin errors++; $display("FAIL nolock_grant2 got %b want 0001", Hgrant); end
    checks++; if (Hmastlock !== 1'b0) begin errors++; $display("FAIL nolock_mastlock got %b want 0", Hmastlock); end
    step(1);
    checks++; if (Hgrant !== 4'b1000) begin errors++; $display("FAIL nolock_grant3 got %b want 1000", Hgrant); end
    checks++; if (Hmastlock !== 1'b0) begin errors++; $display("FAIL nolock_mastlock3 got %b want 0", Hmastlock); end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    make_m1_owner();
    Hbusreq = 4'b0110;
    set_master(1, 2'd2, 3'd6);   // NONSEQ WRAP16
    step(1);
    set_master(1, 2'd3, 3'd6);   // SEQ beat 2
    #2;
    Hresetn = 1'b0;
    #1;
    checks++; if (Hgrant !== 4'b0001) begin errors++; $display("FAIL rst_burst_grant got %b want 0001", Hgrant); end
    checks++; if (Hmaster !== 2'd0) begin errors++; $display("FAIL rst_burst_master got %0d want 0", Hmaster); end
    checks++; if (dut.beat_cnt !== 4'd0) begin errors++; $display("FAIL rst_burst_cnt got %0d want 0", dut.beat_cnt); end
    step(1);
    clear_inputs();
    Hbusreq = 4'b0110;
    Hresetn = 1'b1;
    step(1);
    checks++; if (Hgrant !== 4'b0010) begin errors++; $display("FAIL rst_first_grant got %b want 0010", Hgrant); end
    step(1);
    checks++; if (Hgrant !== 4'b0100) begin errors++; $display("FAIL rst_no_hold got %b want 0100", Hgrant); end
  endtask

  initial begin
    Hresetn = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_latency_park();
    test_burst_hold();
    test_wait_error();
    test_lock();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
